word_stream_tx: RTL and testbench

Parallel-to-serial frame transmitter. It accepts one frame of FOO signed words, each FOO bits wide, presented as an unpacked array in a single handshake. It then emits the words one per cycle on a valid/ready stream, index 0 first, and flags the final word. It is the transmit end for blocks that consume per-word streams and rebuild the `[FOO-1:0] x [FOO]` array form used across the design.

---
 rtl/word_stream_tx.sv | 111 +++++++++++
 tb/tb_word_stream_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/word_stream_tx.sv
// word_stream_tx
// Parallel-to-serial frame transmitter. One handshake captures a whole frame
// of FOO signed FOO-bit words; the words then leave one per cycle on a
// valid/ready stream, index 0 first, with the final word flagged.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   in_valid     frame presented on in_data
//   in_ready     frame accepted this cycle (combinational on out_ready)
//   in_data      frame words, element 0 sent first
//   out_valid    out_data holds a valid word
//   out_ready    sink accepts the word this cycle
//   out_data     current word, buffer[out_index]
//   out_last     current word is element FOO-1
//   out_index    element index of the current word
//   frame_count  frames fully emitted, wraps at 2^32
module word_stream_tx #(
    parameter int FOO = 8,
    parameter int IW  = $clog2(FOO)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [FOO-1:0] in_data [FOO],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [FOO-1:0] out_data,
    output logic                  out_last,
    output logic [IW-1:0]         out_index,
    output logic [31:0]           frame_count
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state, state_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic signed [FOO-1:0] fbuf [FOO];
    logic                  load;
    logic                  cnt_inc;
    logic                  xfer;
    logic                  accept_in;

    assign out_valid = (state == SEND);
    assign out_last  = (state == SEND) && (idx == IW'(FOO - 1));
    assign out_index = idx;
    assign out_data  = fbuf[idx];

    assign xfer      = out_valid && out_ready;
    // A new frame may land on the same edge the last word leaves, so the
    // stream runs back-to-back without a bubble.
    assign in_ready  = (state == IDLE) || (xfer && out_last);
    assign accept_in = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (accept_in) begin
                    state_nxt = SEND;
                    idx_nxt   = '0;
                    load      = 1'b1;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (out_last) begin
                        cnt_inc = 1'b1;
                        idx_nxt = '0;
                        if (accept_in) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            frame_count <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (cnt_inc) frame_count <= frame_count + 32'd1;
        end
    end

    // Frame buffer: in_data is sampled only on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FOO; i++) fbuf[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < FOO; i++) fbuf[i] <= in_data[i];
        end
    end

endmodule

// File: tb/tb_word_stream_tx.sv
module tb_word_stream_tx;

    localparam int FOO = 4;
    localparam int IW  = 2;

    typedef logic signed [FOO-1:0] word_t;
    typedef struct {
        word_t         d;
        logic [IW-1:0] i;
        logic          l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    word_t       in_data [FOO];
    logic        out_valid;
    logic        out_ready = 1'b0;
    word_t       out_data;
    logic        out_last;
    logic [IW-1:0] out_index;
    logic [31:0] frame_count;

    int errors = 0;
    int checks = 0;

    exp_t  sbq [$];
    exp_t  e;
    word_t fa [FOO], fb [FOO], fc [FOO], fd [FOO];

    logic          prev_stall = 1'b0;
    word_t         prev_d;
    logic [IW-1:0] prev_i;

    word_stream_tx #(.FOO(FOO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_index(out_index), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input word_t w [FOO]);
        for (int k = 0; k < FOO; k++) sbq.push_back('{w[k], IW'(k), (k == FOO - 1)});
    endtask

    // Present a frame and return #1 after the edge that accepts it.
    task automatic load(input word_t w [FOO]);
        int n;
        in_data  = w;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("load_timeout", 32'd0, 32'd1);
        push_frame(w);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compares every transferred word, and checks that a
    // stalled word stays put into the next cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_data", 32'(out_data), 32'(prev_d));
                chk("hold_index", 32'(out_index), 32'(prev_i));
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_data", 32'(out_data), 32'(e.d));
                    chk("sb_index", 32'(out_index), 32'(e.i));
                    chk("sb_last", 32'(out_last), 32'(e.l));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_i     = out_index;
        end
    end

    initial begin
        fa = '{4'sh1, 4'sh7, 4'sh8, 4'shF};
        fb = '{4'sh2, 4'sh3, 4'shC, 4'sh5};
        fc = '{4'sh6, 4'shA, 4'sh0, 4'sh9};
        fd = '{4'shE, 4'sh4, 4'shB, 4'sh1};
        in_data = fd;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_frame_count", frame_count, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

        // 1. Single frame, sink always ready
        out_ready = 1'b1;
        load(fa);
        for (int k = 0; k < FOO; k++) begin
            @(negedge clk);
            chk("t1_valid", 32'(out_valid), 32'd1);
            chk("t1_last", 32'(out_last), 32'(k == FOO - 1));
        end
        step();
        chk("t1_count", frame_count, 32'd1);
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        chk("t1_idle", 32'(out_valid), 32'd0);

        // 2. Backpressure 1,0,0,1,1,0,1
        load(fb);
        begin
            logic [6:0] pat;
            pat = 7'b1011001;
            for (int c = 0; c < 7; c++) begin
                out_ready = pat[c];
                step();
            end
        end
        out_ready = 1'b1;
        chk("t2_count", frame_count, 32'd2);
        chk("t2_idle", 32'(out_valid), 32'd0);
        chk("t2_sb_empty", 32'(sbq.size()), 32'd0);

        // 3. Back-to-back frames
        in_data  = fa;
        in_valid = 1'b1;
        @(negedge clk);
        chk("t3_a_ready", 32'(in_ready), 32'd1);
        push_frame(fa);
        step();
        in_data = fb;
        for (int k = 0; k < FOO; k++) begin
            @(negedge clk);
            chk("t3_a_valid", 32'(out_valid), 32'd1);
            chk("t3_in_ready", 32'(in_ready), 32'(k == FOO - 1));
            if (k == FOO - 1) push_frame(fb);
        end
        step();
        in_valid = 1'b0;
        chk("t3_count_a", frame_count, 32'd3);
        for (int k = 0; k < FOO; k++) begin
            @(negedge clk);
            chk("t3_b_valid", 32'(out_valid), 32'd1);
        end
        step();
        chk("t3_count_b", frame_count, 32'd4);
        chk("t3_idle", 32'(out_valid), 32'd0);

        // 4. Load blocked mid-frame
        load(fc);
        step();
        in_data  = fd;
        in_valid = 1'b1;
        @(negedge clk);
        chk("t4_blocked_w1", 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("t4_blocked_w2", 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("t4_accept_last", 32'(in_ready), 32'd1);
        push_frame(fd);
        step();
        in_valid = 1'b0;
        chk("t4_count_c", frame_count, 32'd5);
        repeat (FOO) step();
        chk("t4_count_d", frame_count, 32'd6);
        chk("t4_sb_empty", 32'(sbq.size()), 32'd0);

        // 5. Reset mid-frame
        load(fb);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_count", frame_count, 32'd0);
        chk("t5_index", 32'(out_index), 32'd0);
        chk("t5_data", 32'(out_data), 32'd0);
        sbq.delete();
        step();
        rst_n = 1'b1;
        load(fc);
        @(negedge clk);
        chk("t5_restart_index", 32'(out_index), 32'd0);
        repeat (FOO) step();
        chk("t5_count_after", frame_count, 32'd1);
        chk("t5_sb_empty", 32'(sbq.size()), 32'd0);

        // 6. Counter wrap
        force dut.frame_count = 32'hFFFF_FFFF;
        #1 release dut.frame_count;
        #1 chk("t6_forced", frame_count, 32'hFFFF_FFFF);
        load(fa);
        repeat (FOO) step();
        chk("t6_wrap", frame_count, 32'd0);
        chk("t6_sb_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
